// File: rtl/weight_loader_if.sv
// rtl/weight_loader_if.sv - weight_loader handshake and weight-file write bus
interface weight_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              iStart;
  logic              iValid;
  logic [DATA_W-1:0] iData;
  logic              oReady;
  logic              oWren;
  logic [ADDR_W-1:0] oADDR;
  logic [DATA_W-1:0] oW;
  logic              oBusy;
  logic              oDone;
  logic              oErr;

  // Controller / byte-stream source side
  modport master (
    output iStart, iValid, iData,
    input  oReady, oWren, oADDR, oW, oBusy, oDone, oErr
  );

  // Loader side
  modport slave (
    input  iStart, iValid, iData,
    output oReady, oWren, oADDR, oW, oBusy, oDone, oErr
  );
endinterface

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - kernel weight byte-stream loader (optional checksum: WEIGHT_LOADER_CSUM_EN)
module weight_loader #(
  parameter int NUM_W  = 25,
  parameter int ADDR_W = 5,   // 2**ADDR_W must cover NUM_W
  parameter int DATA_W = 8
) (
  input  logic           iCLK,
  input  logic           iRST,
  weight_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
`ifdef WEIGHT_LOADER_CSUM_EN
    S_CSUM  = 2'd2,
`endif
    S_FLUSH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              wren_q,  wren_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] w_q,     w_d;
  logic              done_q,  done_d;
  logic              ready;
  logic              busy;
`ifdef WEIGHT_LOADER_CSUM_EN
  logic [DATA_W-1:0] sum_q,   sum_d;
  logic              err_q,   err_d;
`endif

  // Ready and busy are pure functions of state so iValid never reaches oReady
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    case (state_q)
      S_LOAD:  begin ready = 1'b1; busy = 1'b1; end
`ifdef WEIGHT_LOADER_CSUM_EN
      S_CSUM:  begin ready = 1'b1; busy = 1'b1; end
`endif
      S_FLUSH: begin ready = 1'b0; busy = 1'b1; end
      default: begin ready = 1'b0; busy = 1'b0; end
    endcase
  end

  // Next-state and registered-output logic for the load sequence
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    w_d     = w_q;
    done_d  = 1'b0;
`ifdef WEIGHT_LOADER_CSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          state_d = S_LOAD;
          index_d = '0;
`ifdef WEIGHT_LOADER_CSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (bus.iValid) begin
          wren_d = 1'b1;
          addr_d = index_q;
          w_d    = bus.iData;
`ifdef WEIGHT_LOADER_CSUM_EN
          sum_d  = sum_q + bus.iData;
`endif
          // Hold the index at the last entry rather than wrapping past it
          if (index_q == LAST_IDX) begin
`ifdef WEIGHT_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_FLUSH;
`endif
          end else begin
            index_d = index_q + ADDR_W'(1);
          end
        end
      end
`ifdef WEIGHT_LOADER_CSUM_EN
      S_CSUM: begin
        if (bus.iValid) begin
          err_d   = (bus.iData != sum_q);
          state_d = S_FLUSH;
        end
      end
`endif
      S_FLUSH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons a load without a done pulse
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      index_q <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      w_q     <= '0;
      done_q  <= 1'b0;
`ifdef WEIGHT_LOADER_CSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      w_q     <= w_d;
      done_q  <= done_d;
`ifdef WEIGHT_LOADER_CSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.oReady = ready;
  assign bus.oBusy  = busy;
  assign bus.oWren  = wren_q;
  assign bus.oADDR  = addr_q;
  assign bus.oW     = w_q;
  assign bus.oDone  = done_q;
`ifdef WEIGHT_LOADER_CSUM_EN
  assign bus.oErr   = err_q;
`else
  assign bus.oErr   = 1'b0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - directed self-checking bench for weight_loader
module tb_weight_loader;
  localparam int NUM_W = 25;
`ifdef WEIGHT_LOADER_CSUM_EN
  localparam int NB = NUM_W + 1;
`else
  localparam int NB = NUM_W;
`endif

  logic clk = 1'b0;
  logic rst;

  weight_loader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  weight_loader #(.NUM_W(NUM_W), .ADDR_W(5), .DATA_W(8)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int hs_cyc[$];
  int done_cnt;
  int done_cyc;
  logic busy_at_done;
  logic err_at_done;
  logic [7:0] pat [NUM_W+1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Log every write strobe and done pulse as seen mid-cycle
  always @(negedge clk) begin
    if (bus.oWren === 1'b1) begin
      wr_addr.push_back(int'(bus.oADDR));
      wr_data.push_back(int'(bus.oW));
      wr_cyc.push_back(cyc);
      expect_eq("wr_addr_range", 32'(bus.oADDR < 5'd25), 32'd1);
    end
    if (bus.oDone === 1'b1) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = bus.oBusy;
      err_at_done  = bus.oErr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); hs_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic fill_pat(input logic [7:0] base, input int incr);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < NUM_W; i++) begin
      pat[i] = (incr != 0) ? 8'(i + 1) : base;
      s = s + pat[i];
    end
    pat[NUM_W] = s;
  endtask

  task automatic pulse_start();
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
  endtask

  // Send n bytes of pat; gap drops iValid for a cycle after each handshake
  task automatic stream(input int n, input int gap, input int start_at);
    for (int i = 0; i < n; i++) begin
      int   tries;
      logic rdy;
      bus.iValid = 1'b1;
      bus.iData  = pat[i];
      bus.iStart = (i == start_at);
      tries = 0;
      do begin
        @(negedge clk);
        rdy = bus.oReady;
        tick();
        tries++;
      end while (!rdy && tries < 20);
      bus.iStart = 1'b0;
      expect_eq("hs_ready", 32'(rdy), 32'd1);
      if (rdy) hs_cyc.push_back(cyc);
      bus.iValid = 1'b0;
      if (gap != 0) tick();
    end
  endtask

  task automatic check_log(input string tag);
    int n;
    expect_eq({tag, "_nwr"}, wr_addr.size(), NUM_W);
    n = (wr_addr.size() < NUM_W) ? wr_addr.size() : NUM_W;
    for (int i = 0; i < n; i++) begin
      expect_eq({tag, "_addr"}, wr_addr[i], i);
      expect_eq({tag, "_data"}, wr_data[i], int'(pat[i]));
      if (i < hs_cyc.size()) expect_eq({tag, "_wr_cyc"}, wr_cyc[i], hs_cyc[i]);
    end
    expect_eq({tag, "_ndone"}, done_cnt, 1);
    if (hs_cyc.size() > 0)
      expect_eq({tag, "_done_cyc"}, done_cyc, hs_cyc[hs_cyc.size()-1] + 1);
    expect_eq({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
  endtask

  task automatic load(input string tag, input int gap, input int start_at);
    clear_logs();
    pulse_start();
    stream(NB, gap, start_at);
    repeat (4) tick();
    check_log(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.iStart = 1'b0;
    bus.iValid = 1'b0;
    bus.iData  = 8'h00;
    done_cnt   = 0;
    repeat (3) tick();
    @(negedge clk);
    expect_eq("rst_wren",  32'(bus.oWren),  32'd0);
    expect_eq("rst_addr",  32'(bus.oADDR),  32'd0);
    expect_eq("rst_w",     32'(bus.oW),     32'd0);
    expect_eq("rst_busy",  32'(bus.oBusy),  32'd0);
    expect_eq("rst_done",  32'(bus.oDone),  32'd0);
    expect_eq("rst_err",   32'(bus.oErr),   32'd0);
    expect_eq("rst_ready", 32'(bus.oReady), 32'd0);
    tick();
    rst = 1'b0;

    // iValid in IDLE without iStart: no ready, no writes
    clear_logs();
    bus.iValid = 1'b1;
    bus.iData  = 8'h77;
    repeat (4) begin
      @(negedge clk);
      expect_eq("idle_ready", 32'(bus.oReady), 32'd0);
      tick();
    end
    bus.iValid = 1'b0;
    expect_eq("idle_nwr", wr_addr.size(), 0);

    // Bytes 1..25, iValid held high; first byte lands at address 0
    fill_pat(8'h00, 1);
    clear_logs();
    pulse_start();
    @(negedge clk);
    expect_eq("load_busy",  32'(bus.oBusy),  32'd1);
    expect_eq("load_ready", 32'(bus.oReady), 32'd1);
    tick();
    stream(NB, 0, -1);
    repeat (4) tick();
    check_log("seq");
    for (int i = 1; i < wr_cyc.size(); i++)
      expect_eq("seq_consecutive", wr_cyc[i] - wr_cyc[i-1], 1);
    expect_eq("seq_err", 32'(err_at_done), 32'd0);
    expect_eq("seq_busy_after", 32'(bus.oBusy), 32'd0);

    // Same stream with iValid low every other cycle
    load("gap", 1, -1);

    // iStart during LOAD around address 10 is ignored
    load("restart_ign", 0, 10);

    // Reset after address 12 is written
    clear_logs();
    pulse_start();
    stream(13, 0, -1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    expect_eq("mid_rst_wren",  32'(bus.oWren),  32'd0);
    expect_eq("mid_rst_addr",  32'(bus.oADDR),  32'd0);
    expect_eq("mid_rst_w",     32'(bus.oW),     32'd0);
    expect_eq("mid_rst_busy",  32'(bus.oBusy),  32'd0);
    expect_eq("mid_rst_done",  32'(bus.oDone),  32'd0);
    expect_eq("mid_rst_ready", 32'(bus.oReady), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    expect_eq("mid_rst_nwr", wr_addr.size(), 13);
    expect_eq("mid_rst_last_addr", (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : -1, 12);
    expect_eq("mid_rst_ndone", done_cnt, 0);

    fill_pat(8'hA5, 0);
    load("a5", 0, -1);
    expect_eq("a5_err", 32'(err_at_done), 32'd0);

`ifdef WEIGHT_LOADER_CSUM_EN
    // All 8'h0B: checksum 275 mod 256 = 8'h13
    fill_pat(8'h0B, 0);
    pat[NUM_W] = 8'h13;
    load("csum_ok", 0, -1);
    expect_eq("csum_ok_err", 32'(err_at_done), 32'd0);

    pat[NUM_W] = 8'h14;
    load("csum_bad", 0, -1);
    expect_eq("csum_bad_err", 32'(err_at_done), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    expect_eq("csum_err_held", 32'(bus.oErr), 32'd1);
    tick();
    pulse_start();
    @(negedge clk);
    expect_eq("csum_err_cleared", 32'(bus.oErr), 32'd0);
    tick();
    pat[NUM_W] = 8'h13;
    clear_logs();
    stream(NB, 0, -1);
    repeat (4) tick();
    check_log("csum_after");
    expect_eq("csum_after_err", 32'(err_at_done), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Upstream sequencer for the 25-entry 5x5 convolution weight register file.
- Accepts a byte stream of kernel weights over a valid/ready handshake after a start pulse.
- Drives the file's write-enable, 5-bit address and 8-bit data ports, writing addresses 0..NUM_W-1 in order.
- Reports completion (oDone) and, optionally, checksum error (oErr) to the controller.

Parameters:
- NUM_W, 25, number of weights per kernel load (addresses 0..NUM_W-1).
- ADDR_W, 5, width of oADDR; must satisfy 2^ADDR_W >= NUM_W.
- DATA_W, 8, weight width.

Ports:
- iCLK  in  1  clock, all logic on rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iStart  in  1  one-cycle pulse: begin a kernel load.
- iValid  in  1  iData holds a valid weight byte.
- iData  in  DATA_W  weight byte stream.
- oReady  out  1  block accepts iData this cycle.
- oWren  out  1  write strobe to weight register file.
- oADDR  out  ADDR_W  weight address.
- oW  out  DATA_W  weight data.
- oBusy  out  1  load in progress.
- oDone  out  1  one-cycle pulse: load complete.
- oErr  out  1  checksum mismatch flag (sticky until next iStart); constant 0 without the optional feature.

Behaviour:
- Reset: the clock sampling iRST=1 forces state=IDLE and index=0. All outputs are 0 (oWren, oADDR, oW, oBusy, oDone, oErr). Reset mid-load abandons the load with no oDone. Entries already written stay in the weight file.
- FSM states: IDLE, LOAD, CSUM (only with the feature), FLUSH.
- IDLE:
  - oReady=0, oBusy=0.
  - iStart=1 -> LOAD; index<=0, sum<=0, oErr<=0.
  - iValid is ignored.
- LOAD:
  - oReady=1, oBusy=1.
  - A handshake (iValid && oReady) at cycle t registers oWren=1, oADDR=index, oW=iData at cycle t+1. index<=index+1; sum<=sum+iData (mod 2^DATA_W).
  - No handshake -> oWren=0 next cycle; oADDR and oW hold their last values.
  - Handshake with index==NUM_W-1 -> CSUM if the feature is enabled, else FLUSH.
- CSUM:
  - oReady=1, oBusy=1, no write generated.
  - Handshake -> oErr <= (iData != sum); go to FLUSH.
- FLUSH:
  - oReady=0, oBusy=1. oWren for the final address (or 0 after CSUM) is visible this cycle.
  - oDone<=1 (seen next cycle); state -> IDLE.
- oDone high exactly one cycle, the cycle after FLUSH, with oBusy=0.
  - Without the feature: final byte handshake at t -> last oWren at t+1 -> oDone at t+2.
- oReady depends on state only: a Moore output with no combinational path from iValid.
- iStart while not in IDLE (including the oDone cycle's preceding FLUSH) is ignored. iStart in the same cycle oDone is high is accepted, since state is IDLE then.
- Never more than one oWren per clock; addresses strictly ascending 0..NUM_W-1; no address >= NUM_W is ever driven with oWren=1.
- index counter is ADDR_W bits and never wraps; its terminal compare is against NUM_W-1.
- Checksum arithmetic is DATA_W-bit unsigned modulo add; carry is discarded.

Optional Feature:
- Macro WEIGHT_LOADER_CSUM_EN.
- Defined: CSUM state present. After the NUM_W weights, one extra byte equal to the modulo-256 sum of the weights is expected. A mismatch sets oErr, which is valid with the oDone pulse and held until the next accepted iStart. Weights are still written regardless of the mismatch.
- Undefined: no CSUM state and no sum register; oErr tied to 0; oDone follows the last weight directly.

Test Plan:
- Reset then iStart; stream bytes 1..25 with iValid held high -> oWren pulses at addresses 0..24 on consecutive cycles with oW=1..25; oDone at cycle 2 after the 25th handshake; oBusy falls with oDone.
- Same stream with iValid low every other cycle -> oWren only on cycles following handshakes; address/data sequence identical; no duplicate or skipped address.
- iStart pulsed during LOAD at address 10 -> ignored; sequence continues to 24; exactly one oDone.
- iRST asserted after address 12 is written -> next cycle all outputs 0 with no oDone. A new iStart plus 25 bytes of 8'hA5 writes addresses 0..24 with 8'hA5.
- CSUM_EN: weights all 8'h0B (sum 275 mod 256 = 8'h13), checksum byte 8'h13 -> oDone with oErr=0. Repeat with checksum 8'h14 -> oErr=1 held until next iStart.
- iValid high in IDLE with no iStart -> oReady=0, no oWren; the first byte after iStart lands at address 0.
